cpu_mem_responder: RTL and testbench
====================================

// Module: cpu_mem_responder
// PURPOSE
//  Memory-side responder for the pipelined LC-3b CPU's two memory ports: port 1 is instruction read, port 2 is data read/write.
//  Arbitrates both ports onto a single-ported physical memory (pmem_*) and returns read data plus a one-cycle response strobe per port.
//  Sits between cpu_datapath and physical memory. Completes the CPU's initiator protocol with mem_resp1/mem_resp2.
// PARAMETERS
//  ADDR_W   16  width of every address bus
//  DATA_W   16  width of every data bus (lc3b_word)
// PORTS
//  clk                input   1       sole clock; all state updates on rising edge
//  reset              input   1       synchronous, active-high reset
//  mem_addr1          input   ADDR_W  port-1 (instruction) read address
//  mem_read1          input   1       port-1 read request, held high until mem_resp1
//  mem_rdata1         output  DATA_W  port-1 read data, valid while mem_resp1=1
//  mem_resp1          output  1       port-1 completion strobe, exactly one cycle
//  mem_addr2          input   ADDR_W  port-2 (data) address
//  mem_read2          input   1       port-2 read request
//  mem_write2         input   1       port-2 write request
//  mem_byte_enable2   input   2       port-2 write byte lanes ([0]=low byte)
//  mem_wdata2         input   DATA_W  port-2 write data
//  mem_rdata2         output  DATA_W  port-2 read data, valid while mem_resp2=1
//  mem_resp2          output  1       port-2 completion strobe, exactly one cycle
//  pmem_address       output  ADDR_W  physical memory address (registered)
//  pmem_read          output  1       physical read strobe (registered)
//  pmem_write         output  1       physical write strobe (registered)
//  pmem_byte_enable   output  2       physical write byte lanes
//  pmem_wdata         output  DATA_W  physical write data
//  pmem_rdata         input   DATA_W  physical read data, valid with pmem_resp
//  pmem_resp          input   1       physical completion, one cycle
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; round-robin pointer (if present)=port 1.
//  FSM states: IDLE, SERVE1, SERVE2, DONE1, DONE2.
//  IDLE: sample requests at the edge.
//    Only port 1 requests -> SERVE1. Only port 2 requests -> SERVE2. Both -> per arbitration. None -> stay in IDLE.
//    On grant, capture address, wdata, byte_enable and operation into registers.
//    Assert pmem_read or pmem_write from the next cycle.
//  SERVEn: hold pmem strobes and captured fields stable.
//    Initiator input changes are ignored until completion.
//    On pmem_resp: drop strobes and register pmem_rdata into mem_rdataN (reads only); go to DONEn.
//  DONEn: mem_respN=1 for this cycle only; then -> IDLE.
//    DONE gives the initiator one cycle to drop or retarget its request before the next sample.
//  mem_rdataN holds its last value between transactions.
//  Write response also pulses mem_resp2, and mem_rdata2 is left unchanged.
//  Latency: request seen at edge 0 -> strobe at cycle 1.
//    If pmem_resp comes in cycle k -> mem_respN in cycle k+1. Minimum is 2 cycles.
//  Port 2 with read2=write2=1: treated as write (protocol error; no assertion).
//  A write with byte_enable=2'b00 still performs the pmem cycle with be=00.
//  pmem_resp while in IDLE or DONE: ignored.
//  Reset mid-SERVE: abort. Strobes are 0 and state is IDLE the cycle after reset.
//    No mem_resp is issued for the aborted access.
//  pmem_resp coinciding with reset: reset wins; no data is captured.
// CONFIGURATION
//  Macro ARB_ROUND_ROBIN_EN:
//  Defined: simultaneous requests are granted to the port not served most recently.
//    The pointer updates at every grant.
//  Undefined: port 2 (data) has fixed priority on simultaneous requests.
//    Port 1 is granted only when port 2 is idle. There is no pointer register.
// TESTING
//  T1 read1 addr=0x0040, pmem returns 0x1234 at cycle 3 -> mem_resp1 at cycle 4, mem_rdata1=0x1234, mem_resp2=0.
//  T2 write2 addr=0x0100, wdata=0xBEEF, be=01 -> pmem_write=1, pmem_address=0x0100, pmem_byte_enable=01 held until resp; mem_resp2 pulses once; mem_rdata2 unchanged.
//  T3 read1 and read2 asserted together, both held -> without macro: port 2 served first, then port 1. With ARB_ROUND_ROBIN_EN: port 1 first, then port 2, then alternating on repeat.
//  T4 change mem_addr1 0x0040->0x0080 during SERVE1 -> pmem_address stays 0x0040 until pmem_resp.
//  T5 reset asserted in SERVE2 one cycle before pmem_resp -> next cycle all outputs 0, no mem_resp2, late pmem_resp ignored.
//  T6 pmem_resp tied high, continuous read1 -> mem_resp1 every 3 cycles (IDLE, SERVE1, DONE1), data in order.

Source files
------------

// File: rtl/cpu_mem_responder_if.sv
// CPU-side and physical-memory-side signals of the memory responder, bundled as one bus.
// slave = the responder; master = everything around it (CPU ports and physical memory).
interface cpu_mem_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // port 1: instruction read
    logic [ADDR_W-1:0] mem_addr1;
    logic              mem_read1;
    logic [DATA_W-1:0] mem_rdata1;
    logic              mem_resp1;
    // port 2: data read/write
    logic [ADDR_W-1:0] mem_addr2;
    logic              mem_read2;
    logic              mem_write2;
    logic [1:0]        mem_byte_enable2;
    logic [DATA_W-1:0] mem_wdata2;
    logic [DATA_W-1:0] mem_rdata2;
    logic              mem_resp2;
    // physical memory
    logic [ADDR_W-1:0] pmem_address;
    logic              pmem_read;
    logic              pmem_write;
    logic [1:0]        pmem_byte_enable;
    logic [DATA_W-1:0] pmem_wdata;
    logic [DATA_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  mem_addr1, mem_read1,
        output mem_rdata1, mem_resp1,
        input  mem_addr2, mem_read2, mem_write2, mem_byte_enable2, mem_wdata2,
        output mem_rdata2, mem_resp2,
        output pmem_address, pmem_read, pmem_write, pmem_byte_enable, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_addr1, mem_read1,
        input  mem_rdata1, mem_resp1,
        output mem_addr2, mem_read2, mem_write2, mem_byte_enable2, mem_wdata2,
        input  mem_rdata2, mem_resp2,
        input  pmem_address, pmem_read, pmem_write, pmem_byte_enable, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// Arbitrates the CPU instruction/data ports onto one physical memory; ARB_ROUND_ROBIN_EN selects round-robin, else data port wins.
// Request-to-mem_respN is 2+ cycles; requests are held until mem_respN, pmem strobes are held until pmem_resp.
module cpu_mem_responder #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    cpu_mem_responder_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SERVE1 = 3'd1,
        SERVE2 = 3'd2,
        DONE1  = 3'd3,
        DONE2  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        be_q, be_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [DATA_W-1:0] rdata2_q, rdata2_d;

    logic req1, req2, prefer2, grant1, grant2;

    assign req1 = bus.mem_read1;
    assign req2 = bus.mem_read2 | bus.mem_write2;

`ifdef ARB_ROUND_ROBIN_EN
    // ptr2_q set means port 2 wins the next tie; cleared at reset so port 1 goes first
    logic ptr2_q, ptr2_d;
    assign prefer2 = ptr2_q;
`else
    assign prefer2 = 1'b1;
`endif

    assign grant2 = req2 & (~req1 | prefer2);
    assign grant1 = req1 & ~grant2;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
`ifdef ARB_ROUND_ROBIN_EN
        ptr2_d   = ptr2_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant2) begin
                    state_d = SERVE2;
                    addr_d  = bus.mem_addr2;
                    wdata_d = bus.mem_wdata2;
                    be_d    = bus.mem_byte_enable2;
                    // read+write together is a protocol error; the write wins
                    wr_d    = bus.mem_write2;
                    rd_d    = ~bus.mem_write2;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr2_d  = 1'b0;
`endif
                end else if (grant1) begin
                    state_d = SERVE1;
                    addr_d  = bus.mem_addr1;
                    wdata_d = '0;
                    be_d    = 2'b00;
                    wr_d    = 1'b0;
                    rd_d    = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr2_d  = 1'b1;
`endif
                end
            end
            SERVE1: begin
                if (bus.pmem_resp) begin
                    state_d  = DONE1;
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    rdata1_d = bus.pmem_rdata;
                end
            end
            SERVE2: begin
                if (bus.pmem_resp) begin
                    state_d = DONE2;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    if (rd_q) begin
                        rdata2_d = bus.pmem_rdata;
                    end
                end
            end
            DONE1:   state_d = IDLE;
            DONE2:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= 2'b00;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            rdata1_q <= '0;
            rdata2_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr2_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr2_q   <= ptr2_d;
`endif
        end
    end

    assign bus.pmem_address     = addr_q;
    assign bus.pmem_read        = rd_q;
    assign bus.pmem_write       = wr_q;
    assign bus.pmem_byte_enable = be_q;
    assign bus.pmem_wdata       = wdata_q;
    assign bus.mem_rdata1       = rdata1_q;
    assign bus.mem_rdata2       = rdata2_q;
    assign bus.mem_resp1        = (state_q == DONE1);
    assign bus.mem_resp2        = (state_q == DONE2);

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: both arbitration builds, holds, reset abort, back-to-back.
module tb_cpu_mem_responder;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [15:0] exp_rdata2;

    cpu_mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    cpu_mem_responder #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.mem_addr1        = '0;
        bus.mem_read1        = 1'b0;
        bus.mem_addr2        = '0;
        bus.mem_read2        = 1'b0;
        bus.mem_write2       = 1'b0;
        bus.mem_byte_enable2 = 2'b00;
        bus.mem_wdata2       = '0;
        bus.pmem_rdata       = '0;
        bus.pmem_resp        = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle_inputs();
        bus.mem_read1 = 1'b1;
        tick();
        tick();
        n_checks++; if (bus.pmem_read !== 1'b0) begin n_fail++; $display("FAIL rst_pmem_read: got %h want 0", bus.pmem_read); end
        n_checks++; if (bus.pmem_write !== 1'b0) begin n_fail++; $display("FAIL rst_pmem_write: got %h want 0", bus.pmem_write); end
        n_checks++; if (bus.pmem_address !== 16'h0) begin n_fail++; $display("FAIL rst_pmem_address: got %h want 0", bus.pmem_address); end
        n_checks++; if ({bus.mem_resp1, bus.mem_resp2} !== 2'b00) begin n_fail++; $display("FAIL rst_resp: got %b want 00", {bus.mem_resp1, bus.mem_resp2}); end
        n_checks++; if ({bus.mem_rdata1, bus.mem_rdata2} !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", {bus.mem_rdata1, bus.mem_rdata2}); end
        n_checks++; if ({bus.pmem_byte_enable, bus.pmem_wdata} !== 18'h0) begin n_fail++; $display("FAIL rst_be_wdata: got %h want 0", {bus.pmem_byte_enable, bus.pmem_wdata}); end
        reset = 1'b0;
        bus.mem_read1 = 1'b0;
        exp_rdata2 = 16'h0;
        tick();
    endtask

    // Both ports held; each transaction takes SERVE, DONE, IDLE.
    task automatic test_arbitration;
        int ord [4];
        int n, last1, last2;
        logic [15:0] d;
`ifdef ARB_ROUND_ROBIN_EN
        ord = '{1, 2, 1, 2};
        n = 4; last1 = 2; last2 = 3;
`else
        ord = '{2, 2, 1, 0};
        n = 3; last1 = 2; last2 = 1;
`endif
        bus.mem_addr1 = 16'h0010; bus.mem_read1 = 1'b1;
        bus.mem_addr2 = 16'h0020; bus.mem_read2 = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            n_checks++; if (bus.pmem_read !== 1'b1) begin n_fail++; $display("FAIL arb_strobe[%0d]: got %h want 1", i, bus.pmem_read); end
            n_checks++; if (bus.pmem_address !== ((ord[i] == 1) ? 16'h0010 : 16'h0020)) begin n_fail++; $display("FAIL arb_order[%0d]: got addr %h want port %0d", i, bus.pmem_address, ord[i]); end
            d = 16'hC000 + 16'(i);
            bus.pmem_rdata = d; bus.pmem_resp = 1'b1;
            tick();
            n_checks++; if ({bus.mem_resp1, bus.mem_resp2} !== {ord[i] == 1, ord[i] == 2}) begin n_fail++; $display("FAIL arb_resp[%0d]: got %b want port %0d", i, {bus.mem_resp1, bus.mem_resp2}, ord[i]); end
            if (ord[i] == 1) begin
                n_checks++; if (bus.mem_rdata1 !== d) begin n_fail++; $display("FAIL arb_rdata1[%0d]: got %h want %h", i, bus.mem_rdata1, d); end
            end else begin
                exp_rdata2 = d;
                n_checks++; if (bus.mem_rdata2 !== d) begin n_fail++; $display("FAIL arb_rdata2[%0d]: got %h want %h", i, bus.mem_rdata2, d); end
            end
            bus.pmem_resp = 1'b0;
            if (i == last1) bus.mem_read1 = 1'b0;
            if (i == last2) bus.mem_read2 = 1'b0;
            tick();
        end
        tick();
        n_checks++; if (bus.pmem_read !== 1'b0) begin n_fail++; $display("FAIL arb_quiet: got %h want 0", bus.pmem_read); end
    endtask

    task automatic test_read1;
        bus.mem_addr1 = 16'h0040; bus.mem_read1 = 1'b1;
        tick();
        n_checks++; if ({bus.pmem_read, bus.pmem_write} !== 2'b10) begin n_fail++; $display("FAIL t1_strobes: got %b want 10", {bus.pmem_read, bus.pmem_write}); end
        n_checks++; if (bus.pmem_address !== 16'h0040) begin n_fail++; $display("FAIL t1_addr: got %h want 0040", bus.pmem_address); end
        tick();
        tick();
        n_checks++; if ({bus.pmem_read, bus.mem_resp1} !== 2'b10) begin n_fail++; $display("FAIL t1_wait: got %b want 10", {bus.pmem_read, bus.mem_resp1}); end
        bus.pmem_rdata = 16'h1234; bus.pmem_resp = 1'b1;
        tick();
        n_checks++; if ({bus.mem_resp1, bus.mem_resp2, bus.pmem_read} !== 3'b100) begin n_fail++; $display("FAIL t1_resp: got %b want 100", {bus.mem_resp1, bus.mem_resp2, bus.pmem_read}); end
        n_checks++; if (bus.mem_rdata1 !== 16'h1234) begin n_fail++; $display("FAIL t1_rdata: got %h want 1234", bus.mem_rdata1); end
        bus.pmem_resp = 1'b0; bus.pmem_rdata = '0; bus.mem_read1 = 1'b0;
        tick();
        n_checks++; if (bus.mem_resp1 !== 1'b0) begin n_fail++; $display("FAIL t1_one_pulse: got %h want 0", bus.mem_resp1); end
        n_checks++; if (bus.mem_rdata1 !== 16'h1234) begin n_fail++; $display("FAIL t1_rdata_hold: got %h want 1234", bus.mem_rdata1); end
    endtask

    task automatic test_write2;
        bus.mem_addr2 = 16'h0100; bus.mem_wdata2 = 16'hBEEF;
        bus.mem_byte_enable2 = 2'b01; bus.mem_write2 = 1'b1;
        tick();
        n_checks++; if ({bus.pmem_read, bus.pmem_write} !== 2'b01) begin n_fail++; $display("FAIL t2_strobes: got %b want 01", {bus.pmem_read, bus.pmem_write}); end
        n_checks++; if ({bus.pmem_address, bus.pmem_byte_enable, bus.pmem_wdata} !== {16'h0100, 2'b01, 16'hBEEF}) begin n_fail++; $display("FAIL t2_fields: got %h want %h", {bus.pmem_address, bus.pmem_byte_enable, bus.pmem_wdata}, {16'h0100, 2'b01, 16'hBEEF}); end
        bus.mem_wdata2 = 16'h0000; bus.mem_byte_enable2 = 2'b10;
        tick();
        n_checks++; if ({bus.pmem_write, bus.pmem_byte_enable, bus.pmem_wdata, bus.mem_resp2} !== {1'b1, 2'b01, 16'hBEEF, 1'b0}) begin n_fail++; $display("FAIL t2_hold: got %h want %h", {bus.pmem_write, bus.pmem_byte_enable, bus.pmem_wdata, bus.mem_resp2}, {1'b1, 2'b01, 16'hBEEF, 1'b0}); end
        bus.pmem_rdata = 16'hDEAD; bus.pmem_resp = 1'b1;
        tick();
        n_checks++; if ({bus.mem_resp2, bus.mem_resp1, bus.pmem_write} !== 3'b100) begin n_fail++; $display("FAIL t2_resp: got %b want 100", {bus.mem_resp2, bus.mem_resp1, bus.pmem_write}); end
        n_checks++; if (bus.mem_rdata2 !== exp_rdata2) begin n_fail++; $display("FAIL t2_rdata2_kept: got %h want %h", bus.mem_rdata2, exp_rdata2); end
        bus.pmem_resp = 1'b0; bus.mem_write2 = 1'b0;
        tick();
        n_checks++; if (bus.mem_resp2 !== 1'b0) begin n_fail++; $display("FAIL t2_one_pulse: got %h want 0", bus.mem_resp2); end
    endtask

    task automatic test_rw_be0;
        bus.mem_addr2 = 16'h0200; bus.mem_wdata2 = 16'h00FF; bus.mem_byte_enable2 = 2'b00;
        bus.mem_read2 = 1'b1; bus.mem_write2 = 1'b1;
        tick();
        n_checks++; if ({bus.pmem_read, bus.pmem_write, bus.pmem_byte_enable} !== 4'b0100) begin n_fail++; $display("FAIL rw_be0_strobes: got %b want 0100", {bus.pmem_read, bus.pmem_write, bus.pmem_byte_enable}); end
        bus.pmem_rdata = 16'h1111; bus.pmem_resp = 1'b1;
        tick();
        n_checks++; if ({bus.mem_resp2, bus.mem_rdata2} !== {1'b1, exp_rdata2}) begin n_fail++; $display("FAIL rw_be0_resp: got %h want %h", {bus.mem_resp2, bus.mem_rdata2}, {1'b1, exp_rdata2}); end
        bus.pmem_resp = 1'b0; bus.mem_read2 = 1'b0; bus.mem_write2 = 1'b0;
        tick();
    endtask

    task automatic test_addr_hold;
        bus.mem_addr1 = 16'h0040; bus.mem_read1 = 1'b1;
        tick();
        n_checks++; if (bus.pmem_address !== 16'h0040) begin n_fail++; $display("FAIL t4_addr_c1: got %h want 0040", bus.pmem_address); end
        bus.mem_addr1 = 16'h0080;
        tick();
        n_checks++; if (bus.pmem_address !== 16'h0040) begin n_fail++; $display("FAIL t4_addr_c2: got %h want 0040", bus.pmem_address); end
        tick();
        n_checks++; if ({bus.pmem_read, bus.pmem_address} !== {1'b1, 16'h0040}) begin n_fail++; $display("FAIL t4_addr_c3: got %h want 10040", {bus.pmem_read, bus.pmem_address}); end
        bus.pmem_rdata = 16'h7777; bus.pmem_resp = 1'b1;
        tick();
        n_checks++; if ({bus.mem_resp1, bus.mem_rdata1} !== {1'b1, 16'h7777}) begin n_fail++; $display("FAIL t4_resp: got %h want 17777", {bus.mem_resp1, bus.mem_rdata1}); end
        bus.pmem_resp = 1'b0; bus.mem_read1 = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_serve;
        bus.mem_addr2 = 16'h0030; bus.mem_read2 = 1'b1;
        tick();
        n_checks++; if (bus.pmem_read !== 1'b1) begin n_fail++; $display("FAIL t5_serve: got %h want 1", bus.pmem_read); end
        reset = 1'b1;
        tick();
        n_checks++; if ({bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.mem_resp2} !== 19'h0) begin n_fail++; $display("FAIL t5_abort: got %h want 0", {bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.mem_resp2}); end
        n_checks++; if ({bus.mem_rdata1, bus.mem_rdata2} !== 32'h0) begin n_fail++; $display("FAIL t5_rdata_clr: got %h want 0", {bus.mem_rdata1, bus.mem_rdata2}); end
        exp_rdata2 = 16'h0;
        reset = 1'b0; bus.mem_read2 = 1'b0;
        bus.pmem_rdata = 16'h9999; bus.pmem_resp = 1'b1;
        tick();
        n_checks++; if ({bus.mem_resp2, bus.pmem_read, bus.mem_rdata2} !== {2'b00, exp_rdata2}) begin n_fail++; $display("FAIL t5_late_resp: got %h want 0", {bus.mem_resp2, bus.pmem_read, bus.mem_rdata2}); end
        bus.pmem_resp = 1'b0;
        tick();
        n_checks++; if (bus.mem_resp2 !== 1'b0) begin n_fail++; $display("FAIL t5_no_resp: got %h want 0", bus.mem_resp2); end
    endtask

    // pmem_resp tied high: IDLE, SERVE1, DONE1 repeating; rdata shows the SERVE-cycle value.
    task automatic test_back_to_back;
        bus.mem_addr1 = 16'h0300; bus.mem_read1 = 1'b1;
        bus.pmem_resp = 1'b1; bus.pmem_rdata = 16'hA000;
        for (int c = 1; c <= 9; c++) begin
            tick();
            n_checks++; if ({bus.mem_resp1, bus.pmem_read} !== {c % 3 == 2, c % 3 == 1}) begin n_fail++; $display("FAIL b2b_phase[%0d]: got %b want %b", c, {bus.mem_resp1, bus.pmem_read}, {c % 3 == 2, c % 3 == 1}); end
            if (c % 3 == 2) begin
                n_checks++; if (bus.mem_rdata1 !== 16'hA000 + 16'(c - 1)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", c, bus.mem_rdata1, 16'hA000 + 16'(c - 1)); end
            end
            bus.pmem_rdata = 16'hA000 + 16'(c);
            if (c == 8) begin
                bus.mem_read1 = 1'b0;
                bus.pmem_resp = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_read1();
        test_write2();
        test_rw_be0();
        test_addr_hold();
        test_reset_mid_serve();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
